// File: rtl/mic_filter_sequencer_if.sv
// Avalon-MM slave bus bundle for the mic filter sequencer register file.
interface mic_filter_sequencer_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/mic_filter_sequencer.sv
// Stages FIR coefficients from Avalon writes and streams them into the mic filter;
// also divides the sample strobe. Define MIC_SEQ_WATCHDOG_EN for the coef_ack watchdog.
module mic_filter_sequencer #(
    parameter int NUM_TAPS = 32,
    parameter int ADDR_W   = 5,
    parameter int COEF_W   = 18,
    parameter int DIV_W    = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    mic_filter_sequencer_if.slave bus,
    output logic [ADDR_W-1:0]     coef_addr,
    output logic [COEF_W-1:0]     coef_data,
    output logic                  coef_we,
    input  logic                  coef_ack,
    output logic                  filter_en,
    output logic                  filter_clr,
    output logic                  sample_tick,
    output logic                  irq
);
    localparam int FILL_W = $clog2(NUM_TAPS + 1);

    typedef enum logic [1:0] {IDLE, CLEAR, WRITE, DONE} state_t;
    state_t state, state_nxt;

    logic [COEF_W-1:0] coef_mem [NUM_TAPS];
    logic [FILL_W-1:0] fill;
    logic [ADDR_W-1:0] idx;
    logic [DIV_W-1:0]  div_q, cnt;
    logic ctrl_en, ctrl_irq_en, sts_done, sts_ovf, sts_tmo;
    logic wr_strobe, wr_ctrl, wr_status, wr_coef, wr_load, wr_div;
    logic busy, full, last, abort, abort_sw, timeout, push_ok;
    logic unused_wdata;

    assign wr_strobe = bus.chipselect & ~bus.write_n;
    assign wr_ctrl   = wr_strobe && (bus.address == 3'd0);
    assign wr_status = wr_strobe && (bus.address == 3'd1);
    assign wr_coef   = wr_strobe && (bus.address == 3'd2);
    assign wr_load   = wr_strobe && (bus.address == 3'd3);
    assign wr_div    = wr_strobe && (bus.address == 3'd4);
    assign unused_wdata = ^bus.writedata;

    assign busy     = (state != IDLE);
    assign full     = (fill == FILL_W'(NUM_TAPS));
    assign last     = (FILL_W'(idx) == fill - FILL_W'(1));
    assign push_ok  = wr_coef && !busy && !full;
    assign abort_sw = wr_ctrl && bus.writedata[2] && busy;
    assign abort    = abort_sw | timeout;

`ifdef MIC_SEQ_WATCHDOG_EN
    // 255th consecutive stalled WRITE cycle forces an abort
    logic [7:0] wd_cnt;
    assign timeout = (state == WRITE) && !coef_ack && (wd_cnt == 8'd254);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                         wd_cnt <= '0;
        else if (state == WRITE && !coef_ack) wd_cnt <= timeout ? 8'd0 : wd_cnt + 8'd1;
        else                                  wd_cnt <= '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                             sts_tmo <= 1'b0;
        else if (timeout)                         sts_tmo <= 1'b1;
        else if (wr_status && bus.writedata[3])   sts_tmo <= 1'b0;
    end
`else
    assign timeout = 1'b0;
    assign sts_tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        coef_we    = 1'b0;
        filter_clr = 1'b0;
        filter_en  = 1'b0;
        case (state)
            IDLE: begin
                filter_en = ctrl_en;
                if (wr_load && fill != '0) state_nxt = CLEAR;
            end
            CLEAR: begin
                filter_clr = 1'b1;
                state_nxt  = WRITE;
            end
            WRITE: begin
                coef_we = 1'b1;
                if (coef_ack && last) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // Outputs are gated so they read 0 outside WRITE, including in reset
    assign coef_addr   = coef_we ? idx : '0;
    assign coef_data   = coef_we ? coef_mem[idx] : '0;
    assign sample_tick = filter_en && (cnt == div_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                            idx <= '0;
        else if (state == CLEAR)                 idx <= '0;
        else if (state == WRITE && coef_ack && !last) idx <= idx + ADDR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (push_ok) coef_mem[ADDR_W'(fill)] <= bus.writedata[COEF_W-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill        <= '0;
            sts_done    <= 1'b0;
            sts_ovf     <= 1'b0;
            ctrl_en     <= 1'b0;
            ctrl_irq_en <= 1'b0;
            div_q       <= '0;
            irq         <= 1'b0;
        end else begin
            if (abort || state == DONE) fill <= '0;
            else if (push_ok)           fill <= fill + FILL_W'(1);

            // Set beats a same-cycle W1C on both sticky flags
            if (state == DONE && !abort)            sts_done <= 1'b1;
            else if (wr_status && bus.writedata[1]) sts_done <= 1'b0;

            if (wr_coef && (busy || full))          sts_ovf <= 1'b1;
            else if (wr_status && bus.writedata[2]) sts_ovf <= 1'b0;

            if (wr_ctrl) begin
                ctrl_en     <= bus.writedata[0];
                ctrl_irq_en <= bus.writedata[1];
            end
            if (wr_div) div_q <= bus.writedata[DIV_W-1:0];

            irq <= (sts_done | sts_tmo) & ctrl_irq_en;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                   cnt <= '0;
        else if (wr_div || !filter_en)  cnt <= '0;
        else if (cnt == div_q)          cnt <= '0;
        else                            cnt <= cnt + DIV_W'(1);
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            3'd0:    bus.readdata = {30'd0, ctrl_irq_en, ctrl_en};
            3'd1:    bus.readdata = {28'd0, sts_tmo, sts_ovf, sts_done, busy};
            3'd2:    bus.readdata = 32'(fill);
            3'd4:    bus.readdata = 32'(div_q);
            default: bus.readdata = '0;
        endcase
    end
endmodule
